// File: rtl/ram_dump_pkg.sv
// ram_dump_pkg: shared definitions for the RAM dump reader.
//   state_t     - reader FSM states (3-bit encoding)
//   DEF_ADDR_W  - default RAM address width
//   DEF_DATA_W  - default RAM word width
//   DEF_DEPTH   - default RAM depth, 2**DEF_ADDR_W
package ram_dump_pkg;

  localparam int unsigned DEF_ADDR_W = 3;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 1 << DEF_ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/ram_dump_reader_if.sv
// ram_dump_reader_if: valid/ready word stream from the dump reader.
//   out_data  - stream word
//   out_valid - word valid
//   out_ready - consumer ready
//   out_last  - final beat of a dump
// Modports: master (reader side), slave (consumer side).
interface ram_dump_reader_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/ram_dump_ctr.sv
// ram_dump_ctr: address / remaining-word register pair for the dump reader.
//   clk, rst  - clock, synchronous active-high reset
//   load      - latch base and clamped count
//   base      - first address
//   count     - requested words (clamped to 2**ADDR_W)
//   step      - advance address (wrapping) and decrement remaining
//   addr      - current read address
//   rem_zero  - remaining count is zero
module ram_dump_ctr #(
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              rem_zero
);

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load) begin
      addr_d = base;
      rem_d  = (count > FULL) ? FULL : count;
    end else if (step) begin
      // address is exactly ADDR_W bits wide, so the increment wraps naturally
      addr_d = addr_q + 1'b1;
      rem_d  = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign addr     = addr_q;
  assign rem_zero = (rem_q == '0);

endmodule

// File: rtl/ram_dump_reader.sv
// ram_dump_reader: on start, reads a wrapping range of a synchronous RAM
// (1-cycle read latency) and streams the words out over valid/ready.
//   clk, rst     - clock, synchronous active-high reset
//   start        - dump request, sampled in IDLE only
//   base_addr    - first RAM address
//   count        - words to read (0 = empty dump, clamped to 2**ADDR_W)
//   ram_rd_en    - RAM read strobe
//   ram_rd_addr  - RAM read address
//   ram_rd_data  - RAM read data, valid the cycle after ram_rd_en
//   strm         - output stream (ram_dump_reader_if.master)
//   busy         - dump in progress
//   done         - one-cycle end-of-dump pulse
// Optional: RAM_DUMP_READER_CHECKSUM_EN appends one XOR-checksum beat.
module ram_dump_reader
  import ram_dump_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  ram_dump_reader_if.master strm,
  output logic              busy,
  output logic              done
);

  state_t state_q, state_d;

  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr;
  logic              rem_zero;
  logic              accept;
  logic              hs;
  logic              final_beat;

  assign accept = (state_q == ST_IDLE) && start;
  assign hs     = (state_q == ST_OUT) && strm.out_ready;

  ram_dump_ctr #(
    .ADDR_W (ADDR_W)
  ) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && (count != '0)),
    .base     (base_addr),
    .count    (count),
    .step     (state_q == ST_CAP),
    .addr     (addr),
    .rem_zero (rem_zero)
  );

`ifdef RAM_DUMP_READER_CHECKSUM_EN
  // chk_q marks that the checksum beat is the one currently presented
  logic              chk_q, chk_d;
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    chk_d  = chk_q;
    if (accept) begin
      csum_d = '0;
      chk_d  = 1'b0;
    end else begin
      if (state_q == ST_CAP) csum_d = csum_q ^ ram_rd_data;
      if (hs && rem_zero)    chk_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
      chk_q  <= 1'b0;
    end else begin
      csum_q <= csum_d;
      chk_q  <= chk_d;
    end
  end

  assign final_beat = rem_zero && chk_q;
`else
  assign final_beat = rem_zero;
`endif

  // stream data register
  always_comb begin
    data_d = data_q;
    if (state_q == ST_CAP) begin
      data_d = ram_rd_data;
`ifdef RAM_DUMP_READER_CHECKSUM_EN
    end else if (hs && rem_zero && !chk_q) begin
      data_d = csum_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = (count == '0) ? ST_DONE : ST_RD;
      ST_RD:   state_d = ST_CAP;
      ST_CAP:  state_d = ST_OUT;
      ST_OUT: begin
        // with the checksum build, exhausted data re-enters OUT for the sum beat
        if (strm.out_ready) begin
          if (final_beat)    state_d = ST_DONE;
          else if (rem_zero) state_d = ST_OUT;
          else               state_d = ST_RD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    ram_rd_en   = (state_q == ST_RD);
    ram_rd_addr = (state_q == ST_RD) ? addr : '0;
    busy        = (state_q == ST_RD) || (state_q == ST_CAP) || (state_q == ST_OUT);
    done        = (state_q == ST_DONE);
  end

  assign strm.out_valid = (state_q == ST_OUT);
  assign strm.out_last  = (state_q == ST_OUT) && final_beat;
  assign strm.out_data  = data_q;

endmodule

// File: tb/tb_ram_dump_reader.sv
module tb_ram_dump_reader;
  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 8;
  localparam int          DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic          busy;
  logic          done;

  ram_dump_reader_if #(.DATA_W(DW)) strm ();

  ram_dump_reader #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .count       (count),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .strm        (strm),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [DEPTH];
  always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, ram_rd_en, 0);
    chk({tag, "_rd_addr"}, ram_rd_addr, 0);
    chk({tag, "_valid"}, strm.out_valid, 0);
    chk({tag, "_last"}, strm.out_last, 0);
    chk({tag, "_data"}, strm.out_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Expected beats come from the plain definition: min(count,DEPTH) words
  // from base upward modulo DEPTH, plus an XOR beat in the checksum build.
  task automatic run_dump(input int b, input int c, input int hold,
                          input bit rnd_ready, input bit noise);
    logic [7:0] exp_d [$];
    bit         exp_l [$];
    int         exp_a [$];
    int         got_a [$];
    int         n;
    logic [7:0] x;
    int         first_v, last_hs, done_t, vcnt;
    bit         prev_stall;
    logic [7:0] prev_d;
    logic       prev_l;
    int         m;
    n = (c > DEPTH) ? DEPTH : c;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_a.push_back((b + i) % DEPTH);
      exp_d.push_back(mem[(b + i) % DEPTH]);
      exp_l.push_back(i == n - 1);
      x ^= mem[(b + i) % DEPTH];
    end
`ifdef RAM_DUMP_READER_CHECKSUM_EN
    if (n > 0) begin
      exp_l[n-1] = 1'b0;
      exp_d.push_back(x);
      exp_l.push_back(1'b1);
    end
`endif
    first_v = -1; last_hs = -1; done_t = -1; vcnt = 0;
    prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;

    start = 1'b1; base_addr = AW'(b); count = (AW+1)'(c);
    @(posedge clk); #1;
    start = 1'b0;

    for (int t = 0; t < 400 && done_t < 0; t++) begin
      if (ram_rd_en) begin
        got_a.push_back(int'(ram_rd_addr));
        chk("rd_while_valid", strm.out_valid, 0);
      end
      if (strm.out_valid && first_v < 0) first_v = t;
      if (prev_stall) begin
        chk("hold_valid", strm.out_valid, 1);
        chk("hold_data", strm.out_data, prev_d);
        chk("hold_last", strm.out_last, prev_l);
      end
      if (done) begin
        done_t = t;
        chk("busy_at_done", busy, 0);
      end else begin
        chk("busy", busy, (c != 0));
      end
      if (strm.out_valid) begin
        if (vcnt < hold) strm.out_ready = 1'b0;
        else             strm.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        vcnt++;
      end else begin
        strm.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (strm.out_valid && strm.out_ready) begin
        if (exp_d.size() == 0) begin
          chk("extra_beat", exp_d.size(), 1);
        end else begin
          chk("beat_data", strm.out_data, exp_d.pop_front());
          chk("beat_last", strm.out_last, exp_l.pop_front());
        end
        last_hs = t;
      end
      prev_stall = strm.out_valid && !strm.out_ready;
      prev_d     = strm.out_data;
      prev_l     = strm.out_last;
      if (noise) begin
        start     = done ? 1'b0 : 1'($urandom_range(0, 1));
        base_addr = AW'($urandom);
        count     = (AW+1)'($urandom);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;

    chk("done_seen", (done_t >= 0), 1);
    chk("done_pulse", done, 0);
    if (c == 0) begin
      chk("done_lat_empty", done_t, 0);
      chk("no_valid_empty", (first_v < 0), 1);
    end else begin
      chk("first_valid_lat", first_v, 2);
      chk("done_lat", done_t, last_hs + 1);
    end
    chk("beats_left", exp_d.size(), 0);
    chk("rd_count", got_a.size(), exp_a.size());
    m = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
    for (int i = 0; i < m; i++) chk("rd_addr", got_a[i], exp_a[i]);
  endtask

  task automatic reset_mid_dump();
    int hs;
    bit found;
    hs = 0; found = 1'b0;
    strm.out_ready = 1'b1;
    start = 1'b1; base_addr = '0; count = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      if (strm.out_valid) begin
        if (hs == 1) found = 1'b1;
        else hs++;
      end
      if (!found) begin
        @(posedge clk); #1;
      end
    end
    chk("reached_beat2", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_idle_outputs("mid_rst");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("no_done_after_rst", done, 0);
      chk("no_valid_after_rst", strm.out_valid, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0;
    strm.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h10 + 8'(i);
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_dump(0, 2, 0, 1'b0, 1'b0);
    run_dump(6, 4, 0, 1'b0, 1'b0);
    run_dump(0, 0, 0, 1'b0, 1'b0);
    run_dump(0, 3, 5, 1'b0, 1'b0);
    reset_mid_dump();
    run_dump(3, 1, 0, 1'b0, 1'b0);
    run_dump(0, 3, 0, 1'b0, 1'b0);
    run_dump(5, 9, 0, 1'b0, 1'b0);
    run_dump(2, 15, 2, 1'b1, 1'b0);

    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
      run_dump(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 3)), 1'b1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
